// File: rtl/nabp_mapper_pkg.sv
// Shared definitions for the NABP mapper LUT.
//   - default widths and table depth
//   - entry_t: one table entry {part, base} at default widths
//   - lane_lsb(): LSB of a lane slice in a flattened lane bus
//   - image_part()/image_base(): the table image (same content as the
//     generated mapper_lut image), one value per angle index
package nabp_mapper_pkg;

  localparam int DEF_ANGLE_WIDTH = 8;
  localparam int DEF_NUM_ANGLES  = 180;
  localparam int DEF_PART_WIDTH  = 16;
  localparam int DEF_BASE_WIDTH  = 16;
  localparam int DEF_NUM_LANES   = 2;
  localparam int DEF_TAG_WIDTH   = 4;

  typedef struct packed {
    logic [DEF_PART_WIDTH-1:0] part;
    logic [DEF_BASE_WIDTH-1:0] base;
  } entry_t;

  // Lane i of a flattened bus occupies [lane_lsb(i, w) +: w].
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Table image. Values are opaque fixed-point words; callers truncate
  // to their configured widths.
  function automatic logic [31:0] image_part(input int unsigned idx);
    return (32'hA000 + idx * 32'd37) & 32'h0000_FFFF;
  endfunction

  function automatic logic [31:0] image_base(input int unsigned idx);
    return ((idx * 32'd131) ^ 32'h0000_5A5A) & 32'h0000_FFFF;
  endfunction

endpackage

// File: rtl/nabp_mapper_lut_bank.sv
// One lane's copy of the mapper table: single-port synchronous read,
// optional write port.
// Macro: NABP_MAPPER_LUT_WRITE_EN -- adds wr_* ports and makes the table
//        a RAM preloaded with the image; otherwise it is a constant ROM.
// Ports:
//   clk, reset          clock, synchronous active-high reset (read reg only)
//   rd_en               capture a new read result this edge
//   rd_addr             angle index; out-of-range reads return zero
//   rd_part, rd_base    registered read data
//   wr_en, wr_addr,
//   wr_part, wr_base    table write (macro on); out-of-range addresses ignored
module nabp_mapper_lut_bank
  import nabp_mapper_pkg::*;
#(
  parameter int ANGLE_WIDTH = DEF_ANGLE_WIDTH,
  parameter int NUM_ANGLES  = DEF_NUM_ANGLES,
  parameter int PART_WIDTH  = DEF_PART_WIDTH,
  parameter int BASE_WIDTH  = DEF_BASE_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic [ANGLE_WIDTH-1:0] rd_addr,
  output logic [PART_WIDTH-1:0]  rd_part,
  output logic [BASE_WIDTH-1:0]  rd_base
`ifdef NABP_MAPPER_LUT_WRITE_EN
  ,
  input  logic                   wr_en,
  input  logic [ANGLE_WIDTH-1:0] wr_addr,
  input  logic [PART_WIDTH-1:0]  wr_part,
  input  logic [BASE_WIDTH-1:0]  wr_base
`endif
);

  localparam int ENTRY_WIDTH = PART_WIDTH + BASE_WIDTH;
  // One extra bit so NUM_ANGLES == 2**ANGLE_WIDTH still compares correctly.
  localparam logic [ANGLE_WIDTH:0] LIMIT = (ANGLE_WIDTH + 1)'(NUM_ANGLES);

  typedef logic [NUM_ANGLES-1:0][ENTRY_WIDTH-1:0] image_t;

  function automatic image_t build_image();
    image_t img;
    for (int i = 0; i < NUM_ANGLES; i++) begin
      img[i] = {PART_WIDTH'(image_part(i)), BASE_WIDTH'(image_base(i))};
    end
    return img;
  endfunction

  logic                   rd_in_range;
  logic [ENTRY_WIDTH-1:0] rd_data;

  assign rd_in_range = {1'b0, rd_addr} < LIMIT;

`ifdef NABP_MAPPER_LUT_WRITE_EN
  logic wr_in_range;
  assign wr_in_range = {1'b0, wr_addr} < LIMIT;

  // NOTE: table storage has no reset; contents survive reset and only the
  // read register below is cleared.
  image_t mem = build_image();

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) mem[wr_addr] <= {wr_part, wr_base};
  end
`else
  localparam image_t mem = build_image();
`endif

  // NOTE: sequential state uses non-blocking assignments so a read on the
  // same edge as a write sees the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

  assign rd_part = rd_data[ENTRY_WIDTH-1:BASE_WIDTH];
  assign rd_base = rd_data[BASE_WIDTH-1:0];

endmodule

// File: rtl/nabp_mapper_lut_pipe.sv
// Pipelined multi-lane mapper LUT: looks up accu_const_part / accu_base
// for NUM_LANES angles per request with valid/ready flow control.
// S1 registers angles, tag and range flags; S2 registers table data.
// Macro: NABP_MAPPER_LUT_WRITE_EN -- adds wr_* runtime table write port
//        (written into every lane's table copy).
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   in_valid/in_ready            request handshake
//   in_angle                     lane i at [i*ANGLE_WIDTH +: ANGLE_WIDTH]
//   in_tag                       sideband tag, returned with the result
//   out_valid/out_ready          result handshake
//   out_accu_const_part/_base    per-lane table data (0 for bad angle)
//   out_err                      per-lane angle >= NUM_ANGLES
//   out_tag                      tag of this result
//   wr_en/wr_addr/wr_part/wr_base  table write (macro on)
module nabp_mapper_lut_pipe
  import nabp_mapper_pkg::*;
#(
  parameter int ANGLE_WIDTH = DEF_ANGLE_WIDTH,
  parameter int NUM_ANGLES  = DEF_NUM_ANGLES,
  parameter int PART_WIDTH  = DEF_PART_WIDTH,
  parameter int BASE_WIDTH  = DEF_BASE_WIDTH,
  parameter int NUM_LANES   = DEF_NUM_LANES,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_LANES*ANGLE_WIDTH-1:0] in_angle,
  input  logic [TAG_WIDTH-1:0]             in_tag,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_LANES*PART_WIDTH-1:0]  out_accu_const_part,
  output logic [NUM_LANES*BASE_WIDTH-1:0]  out_accu_base,
  output logic [NUM_LANES-1:0]             out_err,
  output logic [TAG_WIDTH-1:0]             out_tag
`ifdef NABP_MAPPER_LUT_WRITE_EN
  ,
  input  logic                             wr_en,
  input  logic [ANGLE_WIDTH-1:0]           wr_addr,
  input  logic [PART_WIDTH-1:0]            wr_part,
  input  logic [BASE_WIDTH-1:0]            wr_base
`endif
);

  localparam logic [ANGLE_WIDTH:0] LIMIT = (ANGLE_WIDTH + 1)'(NUM_ANGLES);

  logic                             advance;
  logic [NUM_LANES-1:0]             in_err;
  logic                             s1_valid;
  logic [NUM_LANES*ANGLE_WIDTH-1:0] s1_angle;
  logic [TAG_WIDTH-1:0]             s1_tag;
  logic [NUM_LANES-1:0]             s1_err;

  // Whole pipe moves or holds together; a bubble in S2 never blocks input.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int A_LSB = lane_lsb(i, ANGLE_WIDTH);
    localparam int P_LSB = lane_lsb(i, PART_WIDTH);
    localparam int B_LSB = lane_lsb(i, BASE_WIDTH);

    assign in_err[i] = !({1'b0, in_angle[A_LSB +: ANGLE_WIDTH]} < LIMIT);

    // Bank read register is the S2 data stage; it zeroes bad angles itself.
    nabp_mapper_lut_bank #(
      .ANGLE_WIDTH (ANGLE_WIDTH),
      .NUM_ANGLES  (NUM_ANGLES),
      .PART_WIDTH  (PART_WIDTH),
      .BASE_WIDTH  (BASE_WIDTH)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (advance),
      .rd_addr (s1_angle[A_LSB +: ANGLE_WIDTH]),
      .rd_part (out_accu_const_part[P_LSB +: PART_WIDTH]),
      .rd_base (out_accu_base[B_LSB +: BASE_WIDTH])
`ifdef NABP_MAPPER_LUT_WRITE_EN
      ,
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_part (wr_part),
      .wr_base (wr_base)
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_angle  <= '0;
      s1_tag    <= '0;
      s1_err    <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_err   <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_angle  <= in_angle;
      s1_tag    <= in_tag;
      s1_err    <= in_valid ? in_err : '0;
      out_valid <= s1_valid;
      out_tag   <= s1_tag;
      out_err   <= s1_err;
    end
  end

endmodule
